mac_feeder: RTL and testbench

Initiator-side driver for the pipelined signed MAC. It holds two small vector buffers (operand A and operand B) loaded by a host. On start it clears the MAC accumulator and streams len operand pairs on the MAC's a/b/valid_in interface. It counts the MAC's valid_out pulses and captures the final accumulated f as a single dot-product result.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_feeder_if.sv | 22 ++
 rtl/mac_vec_ram.sv | 22 ++
 rtl/mac_feeder.sv | 184 ++++++++++++++++++
 tb/tb_mac_feeder.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared constants and FSM state type for the MAC feeder slice.
package mac_pkg;
  localparam int DATA_W      = 14;
  localparam int ACC_W       = 28;
  localparam int MAC_LATENCY = 3;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN
  } feeder_state_t;
endpackage

// File: rtl/mac_feeder_if.sv
// Feeder <-> pipelined MAC bus; the feeder is master, the MAC is slave.
interface mac_feeder_if #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int ACC_W  = mac_pkg::ACC_W
);
  logic                     mac_reset;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic                     mac_valid_in;
  logic signed [ACC_W-1:0]  mac_f;
  logic                     mac_valid_out;

  modport master (
    output mac_reset, mac_a, mac_b, mac_valid_in,
    input  mac_f, mac_valid_out
  );

  modport slave (
    input  mac_reset, mac_a, mac_b, mac_valid_in,
    output mac_f, mac_valid_out
  );
endinterface

// File: rtl/mac_vec_ram.sv
// Operand pair buffer: one synchronous write port, one combinational read port.
module mac_vec_ram #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic signed [DATA_W-1:0] wa,
  input  logic signed [DATA_W-1:0] wb,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic signed [DATA_W-1:0] ra,
  output logic signed [DATA_W-1:0] rb
);
  logic [2*DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= {wa, wb};
  end

  assign {ra, rb} = mem_q[raddr];
endmodule

// File: rtl/mac_feeder.sv
// Streams buffered operand pairs into a pipelined MAC and captures the dot product.
// Optional drain watchdog enabled by defining MAC_FEEDER_TIMEOUT_EN.
module mac_feeder #(
  parameter int DATA_W  = mac_pkg::DATA_W,
  parameter int ACC_W   = mac_pkg::ACC_W,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic signed [DATA_W-1:0] load_a,
  input  logic signed [DATA_W-1:0] load_b,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   len,
  mac_feeder_if.master             mac,
  output logic signed [ACC_W-1:0]  result,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     error
);
  import mac_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  feeder_state_t            state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [LW-1:0]            len_q, len_d;
  logic [LW-1:0]            out_cnt_q, out_cnt_d;
  logic signed [DATA_W-1:0] mac_a_q, mac_a_d;
  logic signed [DATA_W-1:0] mac_b_q, mac_b_d;
  logic                     mac_valid_in_q, mac_valid_in_d;
  logic signed [ACC_W-1:0]  result_q, result_d;
  logic                     done_q, done_d;
  logic                     result_valid_q, result_valid_d;

  logic                     ram_we;
  logic [AW-1:0]            rd_idx;
  logic signed [DATA_W-1:0] rd_a, rd_b;

  assign ram_we = load_en && (state_q == IDLE);
  // Read port looks one entry ahead so the next pair is ready at the edge.
  assign rd_idx = (state_q == STREAM) ? idx_q + AW'(1) : '0;

  mac_vec_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (load_addr),
    .wa    (load_a),
    .wb    (load_b),
    .raddr (rd_idx),
    .ra    (rd_a),
    .rb    (rd_b)
  );

`ifdef MAC_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] drain_cnt_q, drain_cnt_d;
  logic          timeout_q, timeout_d;
  logic          error_q, error_d;
`endif

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    out_cnt_d      = out_cnt_q + LW'(busy && mac.mac_valid_out);
    mac_a_d        = mac_a_q;
    mac_b_d        = mac_b_q;
    mac_valid_in_d = mac_valid_in_q;
    result_d       = result_q;
    done_d         = 1'b0;
    result_valid_d = done_q;
`ifdef MAC_FEEDER_TIMEOUT_EN
    drain_cnt_d    = '0;
    timeout_d      = 1'b0;
    error_d        = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
          out_cnt_d = '0;
          idx_d     = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        if (len_q == '0) begin
          result_d = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          mac_a_d        = rd_a;
          mac_b_d        = rd_b;
          mac_valid_in_d = 1'b1;
          idx_d          = '0;
          state_d        = STREAM;
        end
      end
      STREAM: begin
        if (LW'(idx_q) + LW'(1) == len_q) begin
          mac_valid_in_d = 1'b0;
          state_d        = DRAIN;
        end else begin
          idx_d   = idx_q + AW'(1);
          mac_a_d = rd_a;
          mac_b_d = rd_b;
        end
      end
      DRAIN: begin
        if (mac.mac_valid_out && (out_cnt_q + LW'(1) >= len_q)) begin
          result_d = mac.mac_f;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
`ifdef MAC_FEEDER_TIMEOUT_EN
        else if (drain_cnt_q == TW'(TIMEOUT - 1)) begin
          result_d  = mac.mac_f;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
        drain_cnt_d = drain_cnt_q + TW'(1);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      len_q          <= '0;
      out_cnt_q      <= '0;
      mac_a_q        <= '0;
      mac_b_q        <= '0;
      mac_valid_in_q <= 1'b0;
      result_q       <= '0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
`ifdef MAC_FEEDER_TIMEOUT_EN
      drain_cnt_q    <= '0;
      timeout_q      <= 1'b0;
      error_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      out_cnt_q      <= out_cnt_d;
      mac_a_q        <= mac_a_d;
      mac_b_q        <= mac_b_d;
      mac_valid_in_q <= mac_valid_in_d;
      result_q       <= result_d;
      done_q         <= done_d;
      result_valid_q <= result_valid_d;
`ifdef MAC_FEEDER_TIMEOUT_EN
      drain_cnt_q    <= drain_cnt_d;
      timeout_q      <= timeout_d;
      error_q        <= error_d;
`endif
    end
  end

  assign mac.mac_reset    = reset || (state_q == CLEAR);
  assign mac.mac_a        = mac_a_q;
  assign mac.mac_b        = mac_b_q;
  assign mac.mac_valid_in = mac_valid_in_q;
  assign result           = result_q;
  assign result_valid     = result_valid_q;
  assign busy             = (state_q != IDLE);
`ifdef MAC_FEEDER_TIMEOUT_EN
  assign error            = error_q;
`else
  assign error            = 1'b0;
`endif
endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a behavioural 3-cycle saturating MAC.
module tb_mac_feeder;
  localparam int DW      = 14;
  localparam int AWD     = 28;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  reset, load_en, start;
  logic [3:0]            load_addr;
  logic signed [DW-1:0]  load_a, load_b;
  logic [4:0]            len;
  logic signed [AWD-1:0] result;
  logic                  result_valid, busy, error;

  mac_feeder_if #(.DATA_W(DW), .ACC_W(AWD)) bus ();

  mac_feeder #(.DATA_W(DW), .ACC_W(AWD), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_a       (load_a),
    .load_b       (load_b),
    .start        (start),
    .len          (len),
    .mac          (bus.master),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Reference MAC: valid_in sampled at E gives valid_out/f after edge E+2.
  logic                  v0, v1, vout, mute;
  logic signed [AWD-1:0] p0, p1, acc;

  function automatic logic signed [AWD-1:0] sat(input longint s);
    if (s > 134217727) return 28'sd134217727;
    if (s < -134217728) return -28'sd134217728;
    return AWD'(s);
  endfunction

  always @(posedge clk) begin
    if (bus.mac_reset) begin
      v0 <= 1'b0; v1 <= 1'b0; vout <= 1'b0;
      p0 <= '0; p1 <= '0; acc <= '0;
    end else begin
      v0   <= bus.mac_valid_in;
      p0   <= AWD'(bus.mac_a) * AWD'(bus.mac_b);
      v1   <= v0;
      p1   <= p0;
      vout <= v1;
      if (v1) acc <= sat(longint'(acc) + longint'(p1));
    end
  end

  assign bus.mac_f         = acc;
  assign bus.mac_valid_out = vout & ~mute;

  typedef struct {
    logic [4:0]          len;
    logic [15:0][DW-1:0] a;
    logic [15:0][DW-1:0] b;
    longint              exp_res;
    int                  exp_pairs;
    int                  exp_lat;
  } vec_t;

  vec_t vt[9];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_a = v.a[i]; load_b = v.b[i];
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic run(input string nm, input logic [4:0] l, input longint er,
                     input int ep, input int el, input bit disturb);
    int cyc;
    int pairs;
    start = 1'b1; len = l;
    tick();
    start = 1'b0; cyc = 0; pairs = 0;
    chk({nm, "_rv_prev_low"}, result_valid, 0);
    chk({nm, "_busy"}, busy, 1);
    while (!result_valid && cyc < 300) begin
      if (disturb) begin
        load_en = (cyc < 4); start = (cyc < 4); len = 5'd1;
        load_addr = '0; load_a = 14'sd100; load_b = 14'sd100;
      end
      tick();
      cyc++;
      if (bus.mac_valid_in) pairs++;
    end
    load_en = 1'b0; start = 1'b0;
    chk({nm, "_done_seen"}, result_valid, 1);
    chk({nm, "_latency"}, cyc, el);
    chk({nm, "_pairs"}, pairs, ep);
    chk({nm, "_result"}, result, er);
    chk({nm, "_error"}, error, 0);
  endtask

  initial begin
    vec_t z;
    int   cyc;
    bit   bad;
    z.len = '0; z.a = '0; z.b = '0; z.exp_res = 0; z.exp_pairs = 0; z.exp_lat = 0;
    for (int i = 0; i < 9; i++) vt[i] = z;
    vt[0].len = 4; vt[0].exp_res = 70; vt[0].exp_pairs = 4; vt[0].exp_lat = 9;
    for (int i = 0; i < 4; i++) begin vt[0].a[i] = DW'(i + 1); vt[0].b[i] = DW'(i + 5); end
    vt[1].len = 3; vt[1].exp_res = 134217727; vt[1].exp_pairs = 3; vt[1].exp_lat = 8;
    for (int i = 0; i < 3; i++) begin vt[1].a[i] = 14'sd8191; vt[1].b[i] = 14'sd8191; end
    vt[2].len = 3; vt[2].exp_res = -134217728; vt[2].exp_pairs = 3; vt[2].exp_lat = 8;
    for (int i = 0; i < 3; i++) begin vt[2].a[i] = -14'sd8192; vt[2].b[i] = 14'sd8191; end
    vt[3].len = 2; vt[3].exp_res = 5; vt[3].exp_pairs = 2; vt[3].exp_lat = 7;
    vt[3].a[0] = 14'sd1; vt[3].a[1] = 14'sd1; vt[3].b[0] = 14'sd2; vt[3].b[1] = 14'sd3;
    vt[4].len = 4; vt[4].exp_res = 4965; vt[4].exp_pairs = 4; vt[4].exp_lat = 9;
    vt[4].a[0] = -14'sd3; vt[4].a[1] = 14'sd7;  vt[4].a[2] = 14'sd100; vt[4].a[3] = -14'sd1;
    vt[4].b[0] = 14'sd4;  vt[4].b[1] = -14'sd2; vt[4].b[2] = 14'sd50;  vt[4].b[3] = 14'sd9;
    vt[5].len = 1; vt[5].exp_res = 67108864; vt[5].exp_pairs = 1; vt[5].exp_lat = 6;
    vt[5].a[0] = -14'sd8192; vt[5].b[0] = -14'sd8192;
    vt[6] = vt[0]; vt[6].len = 0; vt[6].exp_res = 0; vt[6].exp_pairs = 0; vt[6].exp_lat = 2;
    vt[7].len = 20; vt[7].exp_res = 120; vt[7].exp_pairs = 16; vt[7].exp_lat = 21;
    for (int i = 0; i < 16; i++) begin vt[7].a[i] = 14'sd1; vt[7].b[i] = DW'(i); end
    vt[8] = vt[7]; vt[8].len = 16;

    reset = 1'b1; load_en = 1'b0; start = 1'b0; load_addr = '0;
    load_a = '0; load_b = '0; len = '0; mute = 1'b0;
    tick(); tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_valid_in", bus.mac_valid_in, 0);
    chk("rst_mac_a", bus.mac_a, 0);
    chk("rst_error", error, 0);
    chk("rst_mac_reset", bus.mac_reset, 1);
    reset = 1'b0;
    tick();
    chk("idle_mac_reset", bus.mac_reset, 0);

    for (int i = 0; i < 9; i++) begin
      load_vec(vt[i]);
      run($sformatf("vec%0d", i), vt[i].len, vt[i].exp_res, vt[i].exp_pairs, vt[i].exp_lat, 1'b0);
    end

    // Back-to-back with stale buffer: 1*5+2*6 = 17 only if the MAC was re-cleared.
    load_vec(vt[0]);
    run("b2b_first", 5'd4, 70, 4, 9, 1'b0);
    run("b2b_second", 5'd2, 17, 2, 7, 1'b0);

    run("busy_ignore", 5'd4, 70, 4, 9, 1'b1);
    run("buf_unchanged", 5'd4, 70, 4, 9, 1'b0);

    start = 1'b1; len = 5'd8;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_in_stream", bus.mac_valid_in, 1);
    reset = 1'b1;
    #1;
    chk("mid_mac_reset", bus.mac_reset, 1);
    tick();
    reset = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_valid_in", bus.mac_valid_in, 0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (result_valid || bus.mac_valid_in || busy) bad = 1'b1;
    end
    chk("mid_quiet", bad, 0);
    run("after_reset", 5'd4, 70, 4, 9, 1'b0);

    load_vec(vt[3]);
    mute = 1'b1;
    start = 1'b1; len = 5'd2;
    tick();
    start = 1'b0; cyc = 0;
`ifdef MAC_FEEDER_TIMEOUT_EN
    while (!result_valid && cyc < 300) begin tick(); cyc++; end
    chk("to_latency", cyc, 2 + 2 + TIMEOUT);
    chk("to_result_valid", result_valid, 1);
    chk("to_error", error, 1);
    chk("to_result", result, 5);
    tick();
    chk("to_error_pulse", error, 0);
`else
    bad = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (result_valid || error) bad = 1'b1;
    end
    chk("stall_no_result", bad, 0);
    chk("stall_busy", busy, 1);
    chk("stall_error", error, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif
    mute = 1'b0;
    tick();
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
